dm_arbiter: RTL and testbench

Two-requester front end that shares one single-port, byte-enabled data memory (1-cycle synchronous read) between the CPU MEM-stage port (m0) and a debug/DMA port (m1). It arbitrates round-robin and sequences each access through a small FSM. It converts sub-word loads and stores into word accesses with byte enables, and returns aligned, sign/zero-extended load data. It also flags misaligned and out-of-range accesses without touching memory.

---
 rtl/dm_pkg.sv | 82 ++++++++
 rtl/dm_arbiter_rr.sv | 21 ++
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_arbiter shared types and helpers.
// Op encoding, lane/byte-enable and load-extension functions.
package dm_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  // Undefined encodings fall to the default and report as errors.
  function automatic logic misaligned(input logic [2:0] op,
                                      input logic [1:0] a);
    logic r;
    case (op)
      OP_LW, OP_SW:         r = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = a[0];
      OP_LB, OP_LBU, OP_SB: r = 1'b0;
      default:              r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] op,
                                       input logic [1:0] a);
    logic [3:0] r;
    case (op)
      OP_SB:   r = 4'b0001 << a;
      OP_SH:   r = a[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] op,
                                             input logic [31:0] wd);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{wd[7:0]}};
      OP_SH:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op,
                                         input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr.sv
// Two-way round-robin grant logic.
// On a tie the requester that did not win last time is chosen.
module dm_rr_arb
  import dm_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  // Winner selection and gated one-hot grant.
  always_comb begin
    o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];
    o_gnt    = 2'b00;
    if (i_en && (|i_req))
      o_gnt = o_winner ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shared data-memory front end for CPU (m0) and debug/DMA (m1).
// Arbitrates, sequences one access at a time, formats sub-word data.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DEPTH = 12288,
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic [2:0]       m0_op,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic [2:0]       m1_op,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  dm_state_t   r_state;
  dm_state_t   w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_owner;
  logic        r_last;

  logic [1:0]  w_gnt;
  logic        w_winner;
  logic        w_take;
  logic        w_err;
  logic        w_rv;
  logic        w_er;
  logic [31:0] w_rd;

  // Grants only in IDLE and never while reset is held.
  dm_rr_arb u_arb (
    .i_req    ({m1_req, m0_req}),
    .i_last   (r_last),
    .i_en     ((r_state == ST_IDLE) && reset),
    .o_gnt    (w_gnt),
    .o_winner (w_winner)
  );

  assign w_take = |w_gnt;
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  assign w_err = misaligned(r_op, r_addr[1:0]) ||
                 (r_addr[31:2] >= DEPTH_W);

  assign mem_addr = r_addr[IDX_W+1:2];

  // State register and capture of the granted request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_op    <= w_winner ? m1_op    : m0_op;
        r_addr  <= w_winner ? m1_addr  : m0_addr;
        r_wdata <= w_winner ? m1_wdata : m0_wdata;
      end
    end
  end

  // Next state, memory strobes and completion signals.
  always_comb begin
    w_next    = r_state;
    w_rv      = 1'b0;
    w_er      = 1'b0;
    w_rd      = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_take)
          w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_err) begin
          w_rv   = 1'b1;
          w_er   = 1'b1;
          w_next = ST_IDLE;
        end else if (is_store(r_op)) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_be    = be_of(r_op, r_addr[1:0]);
          mem_wdata = lane_wdata(r_op, r_wdata);
          w_rv      = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          mem_en = 1'b1;
          mem_be = 4'b1111;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rv   = 1'b1;
        w_rd   = extend(r_op, r_addr[1:0], mem_rdata);
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign m0_rvalid = w_rv & ~r_owner;
  assign m0_err    = w_er & ~r_owner;
  assign m0_rdata  = r_owner ? 32'd0 : w_rd;
  assign m1_rvalid = w_rv & r_owner;
  assign m1_err    = w_er & r_owner;
  assign m1_rdata  = r_owner ? w_rd : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory.
// Vector table for single accesses, sequences for arbitration/reset.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [2:0]  m0_op, m1_op;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port byte-enabled memory, one-cycle read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [13:0] ma;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [21];

  task automatic wait_any(input string nm, output logic who);
    int n = 0;
    #1;
    while (!m0_gnt && !m1_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_gnt_seen"}, {31'd0, m0_gnt | m1_gnt}, 32'd1);
    chk({nm, "_gnt_onehot"}, {31'd0, m0_gnt & m1_gnt}, 32'd0);
    who = m1_gnt;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    logic who;
    logic rv, er;
    logic [31:0] rd;
    nm = $sformatf("v%0d", i);
    @(negedge clk);
    if (v.port) begin
      m1_req = 1'b1; m1_op = v.op; m1_addr = v.addr; m1_wdata = v.wd;
    end else begin
      m0_req = 1'b1; m0_op = v.op; m0_addr = v.addr; m0_wdata = v.wd;
    end
    wait_any(nm, who);
    chk({nm, "_winner"}, {31'd0, who}, {31'd0, v.port});
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    rv = v.port ? m1_rvalid : m0_rvalid;
    er = v.port ? m1_err : m0_err;
    rd = v.port ? m1_rdata : m0_rdata;
    chk({nm, "_other_rv"}, {31'd0, v.port ? m0_rvalid : m1_rvalid}, 32'd0);
    if (v.err) begin
      chk({nm, "_mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({nm, "_rvalid"}, {31'd0, rv}, 32'd1);
      chk({nm, "_err"}, {31'd0, er}, 32'd1);
      chk({nm, "_rdata"}, rd, 32'd0);
    end else if (is_store(v.op)) begin
      chk({nm, "_mem_en"}, {31'd0, mem_en}, 32'd1);
      chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd1);
      chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, v.be});
      chk({nm, "_maddr"}, {18'd0, mem_addr}, {18'd0, v.ma});
      chk({nm, "_mwdata"}, mem_wdata, v.mwd);
      chk({nm, "_rvalid"}, {31'd0, rv}, 32'd1);
      chk({nm, "_err"}, {31'd0, er}, 32'd0);
    end else begin
      chk({nm, "_mem_en"}, {31'd0, mem_en}, 32'd1);
      chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({nm, "_be"}, {28'd0, mem_be}, 32'hF);
      chk({nm, "_maddr"}, {18'd0, mem_addr}, {18'd0, v.ma});
      chk({nm, "_early_rv"}, {31'd0, rv}, 32'd0);
      @(negedge clk); #1;
      rv = v.port ? m1_rvalid : m0_rvalid;
      er = v.port ? m1_err : m0_err;
      rd = v.port ? m1_rdata : m0_rdata;
      chk({nm, "_rvalid"}, {31'd0, rv}, 32'd1);
      chk({nm, "_err"}, {31'd0, er}, 32'd0);
      chk({nm, "_rdata"}, rd, v.rd);
      chk({nm, "_mem_en_resp"}, {31'd0, mem_en}, 32'd0);
    end
  endtask

  initial begin
    logic who;
    logic exp_rr [4];
    for (int k = 0; k < 16384; k++) mem[k] = 32'd0;
    mem_rdata = 32'd0;
    vt[0]  = '{1'b0, OP_SW,  32'h10,   32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 14'd4, 32'h0};
    vt[1]  = '{1'b0, OP_SB,  32'h13,   32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 14'd4, 32'h0};
    vt[2]  = '{1'b0, OP_LB,  32'h13,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'hFFFFFFA5};
    vt[3]  = '{1'b0, OP_LBU, 32'h13,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'h000000A5};
    vt[4]  = '{1'b1, OP_LW,  32'h10,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'hA5ADBEEF};
    vt[5]  = '{1'b1, OP_SW,  32'h10,   32'h80017FFF, 1'b0, 4'b1111, 32'h80017FFF, 14'd4, 32'h0};
    vt[6]  = '{1'b0, OP_LH,  32'h12,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'hFFFF8001};
    vt[7]  = '{1'b0, OP_LHU, 32'h12,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'h00008001};
    vt[8]  = '{1'b1, OP_LH,  32'h10,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd4, 32'h00007FFF};
    vt[9]  = '{1'b0, OP_SH,  32'h16,   32'hABCD1234, 1'b0, 4'b1100, 32'h12341234, 14'd5, 32'h0};
    vt[10] = '{1'b1, OP_LW,  32'h14,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd5, 32'h12340000};
    vt[11] = '{1'b1, OP_SB,  32'h15,   32'h00000077, 1'b0, 4'b0010, 32'h77777777, 14'd5, 32'h0};
    vt[12] = '{1'b0, OP_LBU, 32'h15,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd5, 32'h00000077};
    vt[13] = '{1'b0, OP_LB,  32'h16,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd5, 32'h00000034};
    vt[14] = '{1'b0, OP_LW,  32'h11,   32'h0,        1'b1, 4'b0000, 32'h0, 14'd0, 32'h0};
    vt[15] = '{1'b0, OP_SH,  32'h01,   32'h0000FFFF, 1'b1, 4'b0000, 32'h0, 14'd0, 32'h0};
    vt[16] = '{1'b1, OP_LW,  32'hC000, 32'h0,        1'b1, 4'b0000, 32'h0, 14'd0, 32'h0};
    vt[17] = '{1'b0, OP_LW,  32'hBFFC, 32'h0,        1'b0, 4'b1111, 32'h0, 14'h2FFF, 32'h0};
    vt[18] = '{1'b1, OP_SB,  32'h17,   32'h00000080, 1'b0, 4'b1000, 32'h80808080, 14'd5, 32'h0};
    vt[19] = '{1'b1, OP_LH,  32'h16,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd5, 32'hFFFF8034};
    vt[20] = '{1'b0, OP_LHU, 32'h14,   32'h0,        1'b0, 4'b1111, 32'h0, 14'd5, 32'h00007700};

    reset = 1'b0;
    m0_req = 1'b0; m0_op = OP_LW; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_op = OP_LW; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(i, vt[i]);
    chk("err_mem0_untouched", mem[0], 32'd0);
    chk("mem4_final", mem[4], 32'h80017FFF);
    chk("mem5_final", mem[5], 32'h80347700);

    // Round-robin with both requesters held from reset release.
    @(negedge clk);
    reset = 1'b0;
    m0_req = 1'b1; m0_op = OP_SW; m0_addr = 32'h100; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_op = OP_SW; m1_addr = 32'h104; m1_wdata = 32'h2;
    @(negedge clk); #1;
    chk("rr_gnt_in_reset", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int g = 0; g < 4; g++) begin
      wait_any($sformatf("rr%0d", g), who);
      chk($sformatf("rr%0d_who", g), {31'd0, who}, {31'd0, exp_rr[g]});
      @(negedge clk);
    end
    m0_req = 1'b0;
    for (int g = 0; g < 3; g++) begin
      wait_any($sformatf("m1only%0d", g), who);
      chk($sformatf("m1only%0d_who", g), {31'd0, who}, 32'd1);
      @(negedge clk);
    end
    m1_req = 1'b0;
    chk("rr_mem64", mem[64], 32'h1);
    chk("rr_mem65", mem[65], 32'h2);

    // Reset during the response cycle of an m0 load.
    @(negedge clk);
    m0_req = 1'b1; m0_op = OP_LW; m0_addr = 32'h10;
    wait_any("rl", who);
    chk("rl_who", {31'd0, who}, 32'd0);
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk); #1;
    chk("rl_in_resp", {31'd0, m0_rvalid}, 32'd1);
    reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    m1_op = OP_LW; m1_addr = 32'h14;
    @(negedge clk); #1;
    chk("rl_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rl_err", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rl_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rl_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rl_rdata", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rl_first_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); #1;
    chk("rl_after_rdata", m0_rdata, 32'h80017FFF);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
